rns_mac_pipe: RTL and testbench
===============================

// Module: rns_mac_pipe
// PURPOSE
//  Pipelined, handshaked residue-number-system multiply-accumulate unit for the moduli set
//  {2^(N+1)-1, 2^N, 2^N-1}.
//  Two modes:
//  - Elementwise multiply: one result per beat.
//  - Dot product: products are accumulated over a group of beats, closed by in_last.
//  Sits between the RNS forward converter and the reverse converter in the DNN datapath.
//  It is the sequential successor of the combinational set3 multiplier.
// PARAMETERS
//  N        4   base width; ch1 = N+1 bits (mod 2^(N+1)-1), ch2 = N bits (mod 2^N), ch3 = N bits (mod 2^N-1)
//  MAX_LEN  16  maximum beats per dot-product group (>=2)
//  CW       $clog2(MAX_LEN+1)  beat-counter width (derived localparam)
// PORTS
//  clk        in   1     rising-edge clock
//  rst        in   1     synchronous, active-high reset
//  in_valid   in   1     operand beat valid
//  in_ready   out  1     unit can accept a beat
//  in_mode    in   1     0 = elementwise multiply, 1 = dot-product accumulate
//  in_last    in   1     final beat of a group (mode 1 only)
//  a1,b1      in   N+1   channel-1 residues
//  a2,b2      in   N     channel-2 residues
//  a3,b3      in   N     channel-3 residues
//  out_valid  out  1     result valid
//  out_ready  in   1     downstream accepts result
//  r1         out  N+1   channel-1 result
//  r2         out  N     channel-2 result
//  r3         out  N     channel-3 result
//  out_cnt    out  CW    number of products in result (1 in mode 0)
//  err_ovf    out  1     sticky: a group hit MAX_LEN without in_last
// BEHAVIOUR
//  Reset:
//   - out_valid=0, r1/r2/r3=0, out_cnt=0, err_ovf=0.
//   - Accumulators=0, beat counter=0, S1 valid=0, group mode=0.
//   - Reset mid-group discards the partial accumulation.
//  Handshake:
//   - A beat is accepted when in_valid & in_ready.
//   - A result is consumed when out_valid & out_ready.
//   - Global stall: in_ready = ~(out_valid & ~out_ready) i.e. ~out_valid | out_ready.
//   - While stalled, all pipeline state holds and outputs stay stable.
//  Pipeline:
//   - S1 registers the three modular products.
//   - S2 accumulates and/or loads the output register.
//   - Mode 0 latency: result valid 2 cycles after acceptance, throughput 1/cycle.
//   - Mode 1 latency: result valid 2 cycles after the last beat is accepted.
//  Arithmetic per channel:
//   - ch2: low N bits of the product (plain mod 2^N).
//   - ch1, ch3 (mod 2^k-1): fold the 2k-bit product as hi+lo.
//   - Modular add: compute s0=x+y and s1=x+y+1; select s1 when s1 carries out, else s0.
//   - All-ones input is treated as 0; outputs are never all-ones.
//   - Accumulation uses the same modular add.
//  Mode 1 group:
//   - in_mode is sampled on the first beat of a group and held until the group closes.
//   - in_mode on later beats is ignored.
//   - Non-last beat: acc <= acc (+) prod, cnt++.
//   - Last beat: r <= acc (+) prod, out_cnt <= cnt+1, acc <= 0, cnt <= 0, out_valid <= 1.
//   - If the MAX_LEN-th beat arrives without in_last, it is treated as last and err_ovf is set.
//   - err_ovf is cleared only by rst.
//   - A mode-0 beat never disturbs a partially filled mode-1 accumulator, because mode is
//     fixed for the whole group.
//   - in_last is ignored in mode 0.
//  Simultaneous events:
//   - Result consumed and new result loaded in the same cycle: out_valid stays 1 with the new data.
// TESTING (N=4: mod 31, 16, 15)
//  1. Mode 0: a=(7,3,5), b=(9,6,4) -> r=(1,2,5), out_cnt=1, out_valid exactly 2 cycles after accept.
//  2. Mode 1: 3 beats of (7,3,5)x(9,6,4), last on beat 3 -> single result (3,6,0), out_cnt=3.
//  3. All-ones operands: a=(31,15,15), b=(7,7,7) -> r=(0,9,0); r1 and r3 never 31 or 15.
//  4. Back-pressure: out_ready=0 for 5 cycles during a mode-0 stream -> in_ready=0,
//     outputs stable, no loss or duplication after release.
//  5. Overflow: 16 beats with in_last=0 -> result after beat 16 with out_cnt=16, err_ovf=1.
//     The next group then starts clean.
//  6. rst asserted after 2 of 4 mode-1 beats -> all outputs 0.
//     A new 1-beat group then returns exactly that product.

Source files
------------

// File: rtl/rns_mac_pipe.sv
// rns_mac_pipe: pipelined handshaked RNS multiply-accumulate for moduli {2^(N+1)-1, 2^N, 2^N-1}
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_mode/in_last with residues a1,b1 (N+1b),
// a2,b2 and a3,b3 (Nb); out_valid/out_ready with results r1,r2,r3, out_cnt (products in result)
// and sticky err_ovf (a dot-product group reached MAX_LEN beats without in_last).
module rns_mac_pipe #(
  parameter int N = 4,
  parameter int MAX_LEN = 16,
  localparam int CW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic          in_last,
  input  logic [N:0]    a1,
  input  logic [N:0]    b1,
  input  logic [N-1:0]  a2,
  input  logic [N-1:0]  b2,
  input  logic [N-1:0]  a3,
  input  logic [N-1:0]  b3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N:0]    r1,
  output logic [N-1:0]  r2,
  output logic [N-1:0]  r3,
  output logic [CW-1:0] out_cnt,
  output logic          err_ovf
);
  // End-around-carry add: picking x+y+1 when it carries folds 2^k back to 1 and maps 2^k-1 to 0,
  // so results are never all-ones.
  function automatic logic [N:0] madd1(input logic [N:0] x, input logic [N:0] y);
    logic [N+1:0] s0, s1;
    s0 = {1'b0, x} + {1'b0, y};
    s1 = s0 + 1'b1;
    return s1[N+1] ? s1[N:0] : s0[N:0];
  endfunction
  function automatic logic [N-1:0] madd3(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0] s0, s1;
    s0 = {1'b0, x} + {1'b0, y};
    s1 = s0 + 1'b1;
    return s1[N] ? s1[N-1:0] : s0[N-1:0];
  endfunction
  function automatic logic [N:0] mul1(input logic [N:0] x, input logic [N:0] y);
    logic [N:0] xn, yn;
    logic [2*N+1:0] p;
    xn = &x ? '0 : x;
    yn = &y ? '0 : y;
    p = {{(N+1){1'b0}}, xn} * {{(N+1){1'b0}}, yn};
    return madd1(p[2*N+1:N+1], p[N:0]);
  endfunction
  function automatic logic [N-1:0] mul3(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N-1:0] xn, yn;
    logic [2*N-1:0] p;
    xn = &x ? '0 : x;
    yn = &y ? '0 : y;
    p = {{N{1'b0}}, xn} * {{N{1'b0}}, yn};
    return madd3(p[2*N-1:N], p[N-1:0]);
  endfunction
  logic [CW-1:0] cnt, s1_cnt;
  logic g_mode, s1_valid, s1_mode, s1_last, s1_ovf;
  logic [N:0] p1, acc1, sum1;
  logic [N-1:0] p2, p3, acc2, acc3, sum2, sum3, m2;
  logic take, mode_eff, at_max, last_eff;
  assign in_ready = ~out_valid | out_ready;
  assign take = in_valid & in_ready;
  always_comb begin
    mode_eff = (cnt == '0) ? in_mode : g_mode;
    at_max = cnt == CW'(MAX_LEN - 1);
    last_eff = ~mode_eff | in_last | at_max;
    m2 = a2 * b2;
    sum1 = madd1(acc1, p1);
    sum2 = acc2 + p2;
    sum3 = madd3(acc3, p3);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      g_mode <= 1'b0;
      s1_valid <= 1'b0;
      s1_mode <= 1'b0;
      s1_last <= 1'b0;
      s1_ovf <= 1'b0;
      s1_cnt <= '0;
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
      acc1 <= '0;
      acc2 <= '0;
      acc3 <= '0;
      out_valid <= 1'b0;
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
      out_cnt <= '0;
      err_ovf <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (take) begin
        p1 <= mul1(a1, b1);
        p2 <= m2;
        p3 <= mul3(a3, b3);
        s1_mode <= mode_eff;
        s1_last <= last_eff;
        s1_ovf <= mode_eff & at_max & ~in_last;
        s1_cnt <= cnt + 1'b1;
        cnt <= last_eff ? '0 : cnt + 1'b1;
        g_mode <= mode_eff;
      end
      out_valid <= s1_valid & s1_last;
      if (s1_valid & s1_last) begin
        r1 <= s1_mode ? sum1 : p1;
        r2 <= s1_mode ? sum2 : p2;
        r3 <= s1_mode ? sum3 : p3;
        out_cnt <= s1_cnt;
        err_ovf <= err_ovf | s1_ovf;
      end
      if (s1_valid & s1_mode) begin
        acc1 <= s1_last ? '0 : sum1;
        acc2 <= s1_last ? '0 : sum2;
        acc3 <= s1_last ? '0 : sum3;
      end
    end
  end
endmodule

// File: tb/tb_rns_mac_pipe.sv
// tb_rns_mac_pipe: directed self-checking bench for rns_mac_pipe (N=4: mod 31, 16, 15)
module tb_rns_mac_pipe;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_mode = 0, in_last = 0, out_ready = 1;
  logic in_ready, out_valid, err_ovf;
  logic [4:0] a1 = 0, b1 = 0, r1;
  logic [3:0] a2 = 0, b2 = 0, a3 = 0, b3 = 0, r2, r3;
  logic [4:0] out_cnt;
  int total = 0, bad = 0;
  rns_mac_pipe #(.N(4), .MAX_LEN(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_last(in_last), .a1(a1), .b1(b1), .a2(a2), .b2(b2), .a3(a3), .b3(b3),
    .out_valid(out_valid), .out_ready(out_ready), .r1(r1), .r2(r2), .r3(r3),
    .out_cnt(out_cnt), .err_ovf(err_ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [12:0] rv(input int x, input int y, input int z);
    return {5'(x), 4'(y), 4'(z)};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic m, input logic l, input logic [4:0] x1, input logic [3:0] x2,
                      input logic [3:0] x3, input logic [4:0] y1, input logic [3:0] y2,
                      input logic [3:0] y3);
    in_valid = 1; in_mode = m; in_last = l;
    a1 = x1; a2 = x2; a3 = x3; b1 = y1; b2 = y2; b3 = y3;
    step();
    in_valid = 0;
  endtask
  initial begin
    logic [12:0] q[$];
    logic [17:0] held;
    int k, got;
    logic stalled, acc_ok;
    repeat (2) step();
    rst = 0;
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_r", {r1, r2, r3}, 0);
    chk("rst_cnt", out_cnt, 0);
    chk("rst_ovf", err_ovf, 0);
    chk("rst_ready", in_ready, 1);
    // mode 0 latency and value; in_last ignored in mode 0
    beat(0, 1, 7, 3, 5, 9, 6, 4);
    chk("m0_lat1", out_valid, 0);
    step();
    chk("m0_lat2", out_valid, 1);
    chk("m0_r", {r1, r2, r3}, rv(1, 2, 5));
    chk("m0_cnt", out_cnt, 1);
    step();
    chk("m0_pulse", out_valid, 0);
    // mode 1 group; in_mode on later beats is ignored
    beat(1, 0, 7, 3, 5, 9, 6, 4);
    beat(0, 0, 7, 3, 5, 9, 6, 4);
    beat(0, 1, 7, 3, 5, 9, 6, 4);
    chk("m1_early", out_valid, 0);
    step();
    chk("m1_valid", out_valid, 1);
    chk("m1_r", {r1, r2, r3}, rv(3, 6, 0));
    chk("m1_cnt", out_cnt, 3);
    step();
    // all-ones operands read as zero
    beat(0, 0, 31, 15, 15, 7, 7, 7);
    step();
    chk("ones_r", {r1, r2, r3}, rv(0, 9, 0));
    beat(0, 0, 30, 15, 14, 30, 15, 14);
    step();
    chk("near_r", {r1, r2, r3}, rv(1, 1, 1));
    // accumulation reaching the modulus wraps to 0, never to all-ones
    beat(1, 0, 1, 0, 1, 30, 0, 14);
    beat(1, 1, 1, 0, 1, 1, 0, 1);
    step();
    chk("wrap_r", {r1, r2, r3}, rv(0, 0, 0));
    chk("wrap_cnt", out_cnt, 2);
    step();
    // back-pressure on a mode-0 stream
    k = 0; got = 0; stalled = 0; held = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 4 && c < 9);
      in_valid = k < 6;
      in_mode = 0; in_last = 0;
      a1 = 5'(k + 3); a2 = 4'(k + 1); a3 = 4'(k + 2);
      b1 = 5'(k + 5); b2 = 4'd3; b3 = 4'd7;
      #1;
      acc_ok = in_valid & in_ready;
      if (out_valid & !out_ready) begin
        chk("bp_ready", in_ready, 0);
        if (stalled) chk("bp_hold", {r1, r2, r3, out_cnt}, held);
        held = {r1, r2, r3, out_cnt};
        stalled = 1;
      end
      if (out_valid & out_ready) begin
        chk("bp_r", {r1, r2, r3}, q.size() ? q.pop_front() : 13'h1fff);
        got++;
      end
      @(posedge clk);
      #1;
      if (acc_ok) begin
        q.push_back(rv(((k + 3) * (k + 5)) % 31, ((k + 1) * 3) % 16, ((k + 2) * 7) % 15));
        k++;
      end
    end
    in_valid = 0; out_ready = 1;
    chk("bp_stalled", stalled, 1);
    chk("bp_count", got, 6);
    // overflow: 16 beats without in_last
    for (int i = 0; i < 16; i++) beat(1, 0, 1, 1, 1, 1, 1, 1);
    chk("ovf_pre", err_ovf, 0);
    step();
    chk("ovf_valid", out_valid, 1);
    chk("ovf_r", {r1, r2, r3}, rv(16, 0, 1));
    chk("ovf_cnt", out_cnt, 16);
    chk("ovf_flag", err_ovf, 1);
    beat(1, 1, 7, 3, 5, 9, 6, 4);
    step();
    chk("ovf_next_r", {r1, r2, r3}, rv(1, 2, 5));
    chk("ovf_next_cnt", out_cnt, 1);
    chk("ovf_sticky", err_ovf, 1);
    step();
    // reset mid-group
    beat(1, 0, 7, 3, 5, 9, 6, 4);
    beat(1, 0, 7, 3, 5, 9, 6, 4);
    rst = 1;
    step();
    rst = 0;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_r", {r1, r2, r3}, 0);
    chk("mrst_cnt", out_cnt, 0);
    chk("mrst_ovf", err_ovf, 0);
    beat(1, 1, 2, 3, 4, 5, 6, 7);
    step();
    chk("mrst_new_valid", out_valid, 1);
    chk("mrst_new_r", {r1, r2, r3}, rv(10, 2, 13));
    chk("mrst_new_cnt", out_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
